// File: rtl/term_cfg_pkg.sv
// Shared helpers for the terminal-tile configuration front-end:
// size derivation and strobe-shape checks used by RTL and elaboration checks.
package term_cfg_pkg;

    localparam int STROBE_MAX_W = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int num_frames(input int cfg_bits, input int frame_bits);
        return (cfg_bits + frame_bits - 1) / frame_bits;
    endfunction

    function automatic int sel_width(input int frames);
        return (clog2(frames) > 1) ? clog2(frames) : 1;
    endfunction

    function automatic int cfg_width(input int cfg_bits);
        return (cfg_bits > 0) ? cfg_bits : 1;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic is_multi_hot(input logic [STROBE_MAX_W-1:0] v);
        return (v & (v - STROBE_MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/term_tile_cfg_frame_ctrl_if.sv
// Frame column, configuration and readback signals of one terminal tile.
// master = bitstream source / readback requester, slave = the tile controller.
interface term_tile_cfg_frame_ctrl_if #(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int CFG_W              = 80,
    parameter int SEL_W              = 2
);
    logic [FRAME_BITS_PER_ROW-1:0] FrameData;
    logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe;
    logic [FRAME_BITS_PER_ROW-1:0] FrameData_O;
    logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_O;
    logic [CFG_W-1:0]              ConfigBits;
    logic                          ConfigDone;
    logic                          StrobeErr;
    logic                          RB_En;
    logic [SEL_W-1:0]              RB_Sel;
    logic [FRAME_BITS_PER_ROW-1:0] RB_Data;
    logic                          RB_Valid;

    modport master (
        output FrameData, FrameStrobe, RB_En, RB_Sel,
        input  FrameData_O, FrameStrobe_O, ConfigBits, ConfigDone, StrobeErr, RB_Data, RB_Valid
    );

    modport slave (
        input  FrameData, FrameStrobe, RB_En, RB_Sel,
        output FrameData_O, FrameStrobe_O, ConfigBits, ConfigDone, StrobeErr, RB_Data, RB_Valid
    );
endinterface

// File: rtl/term_frame_pipe_stage.sv
// Width x depth delay line for the forwarded frame column; depth 0 is a wire.
module term_frame_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst};
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = d;
            for (int s = 1; s < DEPTH; s++) stage_d[s] = stage_q[s-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/term_tile_cfg_frame_ctrl.sv
// Terminal-tile configuration front-end: forwards the frame column, latches this
// tile's frames, tracks completion, flags multi-hot strobes and serves readback.
module term_tile_cfg_frame_ctrl
    import term_cfg_pkg::*;
#(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int NO_CONFIG_BITS     = 80,
    parameter int PIPE_STAGES        = 1
) (
    input logic                      CLK,
    input logic                      RESET,
    term_tile_cfg_frame_ctrl_if.slave bus
);
    localparam int NUM_FRAMES = num_frames(NO_CONFIG_BITS, FRAME_BITS_PER_ROW);
    localparam int SEL_W      = sel_width(NUM_FRAMES);

    if (NUM_FRAMES > MAX_FRAMES_PER_COL) begin : g_err_frames
        $error("tile owns more frames than the column provides");
    end
    if (PIPE_STAGES < 0 || PIPE_STAGES > 3) begin : g_err_stages
        $error("PIPE_STAGES must be 0..3");
    end
    if (MAX_FRAMES_PER_COL > STROBE_MAX_W) begin : g_err_strobe_w
        $error("strobe column wider than the multi-hot checker");
    end

    term_frame_pipe_stage #(.WIDTH(FRAME_BITS_PER_ROW), .DEPTH(PIPE_STAGES)) u_data_pipe (
        .clk(CLK), .rst(RESET), .d(bus.FrameData), .q(bus.FrameData_O)
    );
    term_frame_pipe_stage #(.WIDTH(MAX_FRAMES_PER_COL), .DEPTH(PIPE_STAGES)) u_strobe_pipe (
        .clk(CLK), .rst(RESET), .d(bus.FrameStrobe), .q(bus.FrameStrobe_O)
    );

    logic multi_hot;
    logic strobe_err_q, strobe_err_d;
    logic rb_valid_q, rb_valid_d;

    assign multi_hot = is_multi_hot(STROBE_MAX_W'(bus.FrameStrobe));

    always_comb begin
        strobe_err_d = strobe_err_q | multi_hot;
        rb_valid_d   = bus.RB_En;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            strobe_err_q <= 1'b0;
            rb_valid_q   <= 1'b0;
        end else begin
            strobe_err_q <= strobe_err_d;
            rb_valid_q   <= rb_valid_d;
        end
    end

    assign bus.StrobeErr = strobe_err_q;
    assign bus.RB_Valid  = rb_valid_q;

    if (NUM_FRAMES > 0) begin : g_bank
        localparam int PAD_W = NUM_FRAMES * FRAME_BITS_PER_ROW;

        logic [PAD_W-1:0]              cfg_q, cfg_d;
        logic [NUM_FRAMES-1:0]         mask_q, mask_d;
        logic                          done_q, done_d;
        logic [FRAME_BITS_PER_ROW-1:0] rb_data_q, rb_data_d;

        always_comb begin
            cfg_d  = cfg_q;
            mask_d = mask_q;
            if (!multi_hot) begin
                for (int f = 0; f < NUM_FRAMES; f++) begin
                    if (bus.FrameStrobe[f]) begin
                        cfg_d[f*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = bus.FrameData;
                        mask_d[f] = 1'b1;
                    end
                end
            end
            // Bits past the owned range stay 0 so readback of the last frame is clean.
            for (int i = NO_CONFIG_BITS; i < PAD_W; i++) cfg_d[i] = 1'b0;

            done_d = &mask_q;

            rb_data_d = rb_data_q;
            if (bus.RB_En) begin
                rb_data_d = '0;
                for (int f = 0; f < NUM_FRAMES; f++) begin
                    if (bus.RB_Sel == SEL_W'(f)) begin
                        rb_data_d = cfg_q[f*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW];
                    end
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                cfg_q     <= '0;
                mask_q    <= '0;
                done_q    <= 1'b0;
                rb_data_q <= '0;
            end else begin
                cfg_q     <= cfg_d;
                mask_q    <= mask_d;
                done_q    <= done_d;
                rb_data_q <= rb_data_d;
            end
        end

        assign bus.ConfigBits = cfg_q[NO_CONFIG_BITS-1:0];
        assign bus.ConfigDone = done_q;
        assign bus.RB_Data    = rb_data_q;
    end else begin : g_no_bank
        logic done_q, done_d;
        logic unused_bank;

        assign done_d      = 1'b1;
        assign unused_bank = ^{bus.FrameData, bus.RB_Sel};

        always_ff @(posedge CLK) begin
            if (RESET) done_q <= 1'b0;
            else       done_q <= done_d;
        end

        assign bus.ConfigBits = '0;
        assign bus.ConfigDone = done_q;
        assign bus.RB_Data    = '0;
    end
endmodule
